// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and elaboration helpers for serial_adder_n.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the width/digit split is usable: at least one bit per step and
  // the operand divides into a whole number of steps.
  function automatic bit params_ok(input int width, input int digit);
    if (width < 1) return 1'b0;
    if (digit < 1) return 1'b0;
    return (width % digit) == 0;
  endfunction

  // Step counter width; a single-step adder still needs a 1-bit counter.
  function automatic int cnt_width(input int nstep);
    if (nstep <= 1) return 1;
    return $clog2(nstep);
  endfunction

endpackage

// File: rtl/serial_adder_n_fa_digit_cell.sv
// fa_digit_cell: DIGIT-bit combinational ripple of full-adder cells. This is
// the only adder hardware in serial_adder_n; it is reused every RUN cycle.
module fa_digit_cell #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // Ripple the carry through DIGIT full-adder cells, LSB first.
  always_comb begin
    logic c;
    c  = ci;
    s  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle WIDTH-bit adder processing DIGIT bits per clock
// through one shared fa_digit_cell, carry held in a register between steps.
// Optional macro SERIAL_ADDER_SUB_EN adds sub_in: B is captured inverted and
// the carry-in inverted, giving A - B - c_in with carry_out = no-borrow.
//
// state | meaning
// IDLE  | ready_out=1, waiting for start_in; operands captured on start
// RUN   | one DIGIT slice per edge, NSTEP edges; result latched on the last
// DONE  | done_out=1 for one cycle, sum_out/carry_out valid, then IDLE
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             done_out
);

  localparam int NSTEP = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int CW    = cnt_width(NSTEP);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_adder_n: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] sl_s;
  logic             sl_co;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH+DIGIT-1:0] r_cat;
  logic [WIDTH-1:0] r_next;
  logic             unused_r_low;

  fa_digit_cell #(.DIGIT(DIGIT)) u_fa (
    .a  (a_sh[DIGIT-1:0]),
    .b  (b_sh[DIGIT-1:0]),
    .ci (cy),
    .s  (sl_s),
    .co (sl_co)
  );

  // Operand conditioning at capture: subtraction is add of ~B with inverted carry-in.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_eff = sub_in ? ~b_in : b_in;
    c_eff = sub_in ? ~c_in : c_in;
`else
    b_eff = b_in;
    c_eff = c_in;
`endif
  end

  // New slice enters at the top of the result register; the oldest low
  // digit falls off (it only ever held pre-run filler).
  assign r_cat        = {sl_s, r_sh};
  assign r_next       = r_cat[WIDTH+DIGIT-1:DIGIT];
  assign unused_r_low = ^r_cat[DIGIT-1:0];

  // Sequencer, datapath shift registers and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      ready_out <= 1'b1;
      done_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sh      <= a_in;
            b_sh      <= b_eff;
            cy        <= c_eff;
            cnt       <= '0;
            state     <= RUN;
            ready_out <= 1'b0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          r_sh <= r_next;
          cy   <= sl_co;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_out   <= r_next;
            carry_out <= sl_co;
            done_out  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done_out  <= 1'b0;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: several serial_adder_n configurations side by side,
// checked every cycle against a latency/arithmetic model plus literal cases.
module tb_serial_adder_n;

  localparam int NI = 9;
  localparam int WS[NI] = '{8, 8, 1, 7, 7, 16, 16, 16, 8};
  localparam int DS[NI] = '{1, 4, 1, 1, 7, 1, 4, 16, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start[NI];
  logic [15:0] a[NI];
  logic [15:0] b[NI];
  logic        c[NI];
  logic        sub[NI];
  logic [15:0] sum_w[NI];
  logic        cy_w[NI];
  logic        rdy_w[NI];
  logic        dn_w[NI];

  int n_checks = 0;
  int n_fail = 0;
  int n_done[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = WS[g];
    localparam int D = DS[g];
    logic [W-1:0] s;
    serial_adder_n #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk_in    (clk),
      .rst_n_in  (rst_n),
      .start_in  (start[g]),
      .a_in      (a[g][W-1:0]),
      .b_in      (b[g][W-1:0]),
      .c_in      (c[g]),
`ifdef SERIAL_ADDER_SUB_EN
      .sub_in    (sub[g]),
`endif
      .ready_out (rdy_w[g]),
      .sum_out   (s),
      .carry_out (cy_w[g]),
      .done_out  (dn_w[g])
    );
    assign sum_w[g] = 16'(s);
  end

  function automatic void chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h", nm, i, act, exp);
    end
  endfunction

  // Reference arithmetic: plain integer add or subtract, modulo 2^w.
  function automatic void ref_op(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                 input logic cc, input logic ss,
                                 output logic [15:0] rs, output logic rc);
    longint m, av, bv, full;
    m  = longint'(1) << w;
    av = longint'(aa) % m;
    bv = longint'(bb) % m;
    if (ss) begin
      full = av - bv - longint'(cc);
      rc   = (full >= 0);
      rs   = 16'((full + m) % m);
    end else begin
      full = av + bv + longint'(cc);
      rc   = (full >= m);
      rs   = 16'(full % m);
    end
  endfunction

  // Timeline model: phase 0 = ready; acceptance at edge E0 sets phase 1;
  // phase NSTEP+1 (reached at edge E0+NSTEP) is the done cycle.
  int          phase[NI];
  logic [15:0] pend_s[NI];
  logic        pend_c[NI];
  logic [15:0] held_s[NI];
  logic        held_c[NI];

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] ts;
    logic        tc;
    logic        s_eff;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        phase[i]  <= 0;
        held_s[i] <= '0;
        held_c[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (phase[i] == 0) begin
          if (start[i]) begin
`ifdef SERIAL_ADDER_SUB_EN
            s_eff = sub[i];
`else
            s_eff = 1'b0;
`endif
            ref_op(WS[i], a[i], b[i], c[i], s_eff, ts, tc);
            pend_s[i] <= ts;
            pend_c[i] <= tc;
            phase[i]  <= 1;
          end
        end else if (phase[i] == WS[i] / DS[i] + 1) begin
          phase[i] <= 0;
        end else begin
          phase[i] <= phase[i] + 1;
          if (phase[i] == WS[i] / DS[i]) begin
            held_s[i] <= pend_s[i];
            held_c[i] <= pend_c[i];
          end
        end
      end
    end
  end

  // Every-cycle compare of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("ready", i, 16'(rdy_w[i]), 16'(phase[i] == 0));
      chk("done", i, 16'(dn_w[i]), 16'(phase[i] == WS[i] / DS[i] + 1));
      chk("sum", i, sum_w[i], held_s[i]);
      chk("carry", i, 16'(cy_w[i]), 16'(held_c[i]));
      if (dn_w[i]) n_done[i]++;
    end
  end

  task automatic go(input int i, input logic [15:0] aa, input logic [15:0] bb,
                    input logic cc, input logic ss);
    int k;
    k = 0;
    while (!rdy_w[i] && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rdy_w[i]) chk("ready_timeout", i, 16'(rdy_w[i]), 16'd1);
    a[i] = aa; b[i] = bb; c[i] = cc; sub[i] = ss; start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int e);
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
    end while (!dn_w[i] && e < 64);
    if (!dn_w[i]) chk("done_timeout", i, 16'(dn_w[i]), 16'd1);
  endtask

  initial begin
    int e;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; a[i] = '0; b[i] = '0; c[i] = 1'b0; sub[i] = 1'b0; n_done[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 0, 16'(rdy_w[0]), 16'd1);
    chk("rst_done", 0, 16'(dn_w[0]), 16'd0);
    chk("rst_sum", 0, sum_w[0], 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8/1: FF + 01 wraps to 00 with carry, eight edges after acceptance.
    go(0, 16'hFF, 16'h01, 1'b0, 1'b0);
    wait_done(0, e);
    chk("t1_latency", 0, 16'(e), 16'd8);
    chk("t1_sum", 0, sum_w[0], 16'h00);
    chk("t1_carry", 0, 16'(cy_w[0]), 16'd1);
    @(posedge clk); #1;
    chk("t1_ready_back", 0, 16'(rdy_w[0]), 16'd1);

    // 8/4: 3C + 47 + 1 = 84, two RUN edges.
    go(1, 16'h3C, 16'h47, 1'b1, 1'b0);
    wait_done(1, e);
    chk("t2_latency", 1, 16'(e), 16'd2);
    chk("t2_sum", 1, sum_w[1], 16'h84);
    chk("t2_carry", 1, 16'(cy_w[1]), 16'd0);

    // start held high: operands change after the first acceptance.
    a[0] = 16'd1; b[0] = 16'd2; c[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    a[0] = 16'd5; b[0] = 16'd6;
    wait_done(0, e);
    chk("t3_latency", 0, 16'(e), 16'd8);
    chk("t3_sum_first", 0, sum_w[0], 16'h03);
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
      if (e == 5) begin
        chk("t3_hold_sum", 0, sum_w[0], 16'h03);
        chk("t3_busy", 0, 16'(rdy_w[0]), 16'd0);
      end
    end while (!dn_w[0] && e < 64);
    chk("t3_gap", 0, 16'(e), 16'd10);
    chk("t3_sum_second", 0, sum_w[0], 16'h0B);
    start[0] = 1'b0;
    @(posedge clk); #1;

    // Reset three edges into a run discards it.
    go(0, 16'hFF, 16'hFF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_sum", 0, sum_w[0], 16'h00);
    chk("t4_rst_carry", 0, 16'(cy_w[0]), 16'd0);
    chk("t4_rst_ready", 0, 16'(rdy_w[0]), 16'd1);
    chk("t4_rst_done", 0, 16'(dn_w[0]), 16'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go(0, 16'h10, 16'h20, 1'b0, 1'b0);
    wait_done(0, e);
    chk("t4_sum", 0, sum_w[0], 16'h30);
    chk("t4_carry", 0, 16'(cy_w[0]), 16'd0);

`ifdef SERIAL_ADDER_SUB_EN
    go(8, 16'h05, 16'h07, 1'b0, 1'b1);
    wait_done(8, e);
    chk("sub_neg_sum", 8, sum_w[8], 16'hFE);
    chk("sub_neg_carry", 8, 16'(cy_w[8]), 16'd0);
    go(8, 16'h07, 16'h05, 1'b0, 1'b1);
    wait_done(8, e);
    chk("sub_pos_sum", 8, sum_w[8], 16'h02);
    chk("sub_pos_carry", 8, 16'(cy_w[8]), 16'd1);
`endif

    // Random sweep: starts arrive at random, including while busy.
    repeat (3000) begin
      for (int i = 0; i < NI; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        a[i]     = 16'($urandom);
        b[i]     = 16'($urandom);
        c[i]     = 1'($urandom_range(0, 1));
        sub[i]   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk("done_seen", i, 16'(n_done[i] > 20), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
